rotary_decoder: RTL and testbench

ROTARY_DECODER -- requirements
Module: rotary_decoder

---
 rtl/rotary_decoder.sv | 111 +++++++++++
 tb/tb_rotary_decoder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_decoder.sv
// Quadrature rotary decoder: 2-flop sync, per-phase debounce, detent step/direction/position, glitch flag.
// Latency: input edge -> filtered phase DEBOUNCE+2 edges -> step_pulse/position DEBOUNCE+3 edges; no backpressure.
module rotary_decoder #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ROT_A,
  input  logic             ROT_B,
  input  logic             clear,
  output logic             rotation_event,
  output logic             step_pulse,
  output logic             direction,
  output logic [WIDTH-1:0] position,
  output logic             glitch
);

  localparam logic [7:0]       DB_LAST = 8'(DEBOUNCE - 1);
  localparam logic [WIDTH-1:0] POS_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] POS_MAX = '1;

  // Bit 0 carries phase A, bit 1 carries phase B.
  logic [1:0]      s1_q, s1_d;
  logic [1:0]      s2_q, s2_d;
  logic [1:0]      filt_q, filt_d;
  logic [1:0]      filt_prev_q, filt_prev_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic            rot_q, rot_d;
  logic            step_q, step_d;
  logic            dir_q, dir_d;
  logic            glitch_q, glitch_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [1:0]      chg;

  always_comb begin
    s1_d        = {ROT_B, ROT_A};
    s2_d        = s1_q;
    filt_d      = filt_q;
    filt_prev_d = filt_q;
    cnt_d       = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          filt_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // A detent is the rising edge of rotation_event produced by exactly one phase moving.
  always_comb begin
    chg      = filt_q ^ filt_prev_q;
    step_d   = (filt_q == 2'b11) && !rot_q && (chg[0] ^ chg[1]);
    glitch_d = &chg;
    if (filt_q == 2'b11) begin
      rot_d = 1'b1;
    end else if (filt_q == 2'b00) begin
      rot_d = 1'b0;
    end else begin
      rot_d = rot_q;
    end
    dir_d = step_d ? filt_prev_q[0] : dir_q;
    pos_d = pos_q;
    if (clear) begin
      pos_d = '0;
    end else if (step_d) begin
      if (dir_d) begin
        if (!(SATURATE && (pos_q == POS_MAX))) pos_d = pos_q + POS_ONE;
      end else begin
        if (!(SATURATE && (pos_q == '0))) pos_d = pos_q - POS_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      cnt_q       <= '0;
      rot_q       <= 1'b0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      glitch_q    <= 1'b0;
      pos_q       <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      cnt_q       <= cnt_d;
      rot_q       <= rot_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      glitch_q    <= glitch_d;
      pos_q       <= pos_d;
    end
  end

  assign rotation_event = rot_q;
  assign step_pulse     = step_q;
  assign direction      = dir_q;
  assign position       = pos_q;
  assign glitch         = glitch_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// Bench for rotary_decoder: wrapping and saturating instances share stimulus and are scored
// against a window-based reference model plus directed scenario checks.
module tb_rotary_decoder;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ROT_A = 1'b0;
  logic ROT_B = 1'b0;
  logic clear = 1'b0;

  logic       rot0, step0, dir0, glitch0;
  logic [7:0] pos0;
  logic       rot1, step1, dir1, glitch1;
  logic [7:0] pos1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  rotary_decoder #(.WIDTH(8), .DEBOUNCE(DB), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .ROT_A(ROT_A), .ROT_B(ROT_B), .clear(clear),
    .rotation_event(rot0), .step_pulse(step0), .direction(dir0),
    .position(pos0), .glitch(glitch0)
  );

  rotary_decoder #(.WIDTH(8), .DEBOUNCE(DB), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ROT_A(ROT_A), .ROT_B(ROT_B), .clear(clear),
    .rotation_event(rot1), .step_pulse(step1), .direction(dir1),
    .position(pos1), .glitch(glitch1)
  );

  // Reference model: sync is a 2-sample delay; a filtered phase flips once the last DB
  // synchronised samples all disagree with it; detents judged from filtered transitions.
  bit ms1a, ms1b, ms2a, ms2b, mfa, mfb, mpa, mpb;
  bit m_rot, m_step, m_dir, m_glitch;
  int mpos_wrap, mpos_sat;
  bit wa[$];
  bit wb[$];

  function automatic bit all_differ(input bit q[$], input bit f);
    if (q.size() < DB) return 1'b0;
    foreach (q[i]) if (q[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      ms1a = 0; ms1b = 0; ms2a = 0; ms2b = 0; mfa = 0; mfb = 0; mpa = 0; mpb = 0;
      m_rot = 0; m_step = 0; m_dir = 0; m_glitch = 0; mpos_wrap = 0; mpos_sat = 0;
      wa.delete(); wb.delete();
    end else begin
      m_step   = mfa && mfb && !m_rot && ((mfa != mpa) != (mfb != mpb));
      m_glitch = (mfa != mpa) && (mfb != mpb);
      if (m_step) begin
        m_dir = mpa;
        if (m_dir) begin
          mpos_wrap = (mpos_wrap + 1) % 256;
          if (mpos_sat < 255) mpos_sat = mpos_sat + 1;
        end else begin
          mpos_wrap = (mpos_wrap + 255) % 256;
          if (mpos_sat > 0) mpos_sat = mpos_sat - 1;
        end
      end
      if (clear) begin
        mpos_wrap = 0;
        mpos_sat  = 0;
      end
      if (mfa && mfb) m_rot = 1;
      else if (!mfa && !mfb) m_rot = 0;
      mpa = mfa;
      mpb = mfb;
      wa.push_back(ms2a);
      wb.push_back(ms2b);
      if (wa.size() > DB) void'(wa.pop_front());
      if (wb.size() > DB) void'(wb.pop_front());
      if (all_differ(wa, mfa)) mfa = ms2a;
      if (all_differ(wb, mfb)) mfb = ms2b;
      ms2a = ms1a; ms2b = ms1b;
      ms1a = ROT_A; ms1b = ROT_B;
    end
  end

  logic [11:0] obs0, obs1, exp0, exp1;
  assign obs0 = {rot0, step0, dir0, glitch0, pos0};
  assign obs1 = {rot1, step1, dir1, glitch1, pos1};
  assign exp0 = {m_rot, m_step, m_dir, m_glitch, mpos_wrap[7:0]};
  assign exp1 = {m_rot, m_step, m_dir, m_glitch, mpos_sat[7:0]};

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (obs0 !== exp0) begin
        errors++;
        $display("FAIL model_wrap t=%0t got %h want %h", $time, obs0, exp0);
      end
      checks++;
      if (obs1 !== exp1) begin
        errors++;
        $display("FAIL model_sat t=%0t got %h want %h", $time, obs1, exp1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ROT_A = 1'b0; ROT_B = 1'b0; clear = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic detent_cw();
    ROT_A = 1'b1; repeat (8) tick();
    ROT_B = 1'b1; repeat (8) tick();
    ROT_A = 1'b0; repeat (8) tick();
    ROT_B = 1'b0; repeat (8) tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; ROT_A = 1'b1; ROT_B = 1'b1; clear = 1'b1;
    tick();
    checks++;
    if ({obs0, obs1} !== 24'h0) begin
      errors++;
      $display("FAIL reset_state got %h_%h want 0", obs0, obs1);
    end
    do_reset();
    mon_en = 1'b1;
  endtask

  task automatic test_cw();
    int n;
    do_reset();
    ROT_A = 1'b1; repeat (20) tick();
    ROT_B = 1'b1;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (step0 && n == 0) n = i;
    end
    checks++;
    if (n != DB + 3) begin errors++; $display("FAIL cw_latency got %0d want %0d", n, DB + 3); end
    checks++;
    if ({dir0, pos0, dir1, pos1} !== {1'b1, 8'd1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL cw_result got dir %b pos %0d / dir %b pos %0d want 1/1", dir0, pos0, dir1, pos1);
    end
  endtask

  task automatic test_ccw();
    int n;
    do_reset();
    ROT_B = 1'b1; repeat (20) tick();
    ROT_A = 1'b1;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (step0 && n == 0) n = i;
    end
    checks++;
    if (n != DB + 3) begin errors++; $display("FAIL ccw_latency got %0d want %0d", n, DB + 3); end
    checks++;
    if ({dir0, pos0, dir1, pos1} !== {1'b0, 8'd255, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL ccw_result got dir %b pos %0d / dir %b pos %0d want 0/255 0/0", dir0, pos0, dir1, pos1);
    end
  endtask

  task automatic test_short_pulse();
    bit seen;
    do_reset();
    ROT_B = 1'b1; repeat (20) tick();
    ROT_A = 1'b1; repeat (3) tick();
    ROT_A = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (rot0 || step0 || pos0 != 8'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL short_pulse got activity 1 want 0"); end
  endtask

  task automatic test_glitch();
    int g;
    bit st;
    do_reset();
    ROT_A = 1'b1; ROT_B = 1'b1;
    g = 0; st = 1'b0;
    repeat (15) begin
      tick();
      if (glitch0) g++;
      if (step0) st = 1'b1;
    end
    checks++;
    if (g != 1) begin errors++; $display("FAIL glitch_count got %0d want 1", g); end
    checks++;
    if ({rot0, st, pos0} !== {1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL glitch_effect got rot %b step %b pos %0d want 1 0 0", rot0, st, pos0);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int n;
    do_reset();
    ROT_B = 1'b1; repeat (20) tick();
    ROT_A = 1'b1; repeat (4) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({obs0, obs1} !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset_state got %h_%h want 0", obs0, obs1);
    end
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (glitch0 && n == 0) n = i;
    end
    checks++;
    if (n != DB + 3) begin errors++; $display("FAIL refilter_latency got %0d want %0d", n, DB + 3); end
    checks++;
    if ({rot0, pos0} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL refilter_state got rot %b pos %0d want 1 0", rot0, pos0);
    end
  endtask

  task automatic test_limits_and_clear();
    do_reset();
    repeat (255) detent_cw();
    checks++;
    if ({pos0, pos1} !== {8'd255, 8'd255}) begin
      errors++;
      $display("FAIL limit_reach got %0d/%0d want 255/255", pos0, pos1);
    end
    ROT_A = 1'b1; repeat (8) tick();
    ROT_B = 1'b1; repeat (7) tick();
    checks++;
    if ({step0, pos0, step1, dir1, pos1} !== {1'b1, 8'd0, 1'b1, 1'b1, 8'd255}) begin
      errors++;
      $display("FAIL wrap_vs_sat got step %b pos %0d / step %b dir %b pos %0d want 1 0 / 1 1 255",
               step0, pos0, step1, dir1, pos1);
    end
    tick();
    ROT_A = 1'b0; repeat (8) tick();
    ROT_B = 1'b0; repeat (8) tick();
    ROT_A = 1'b1; repeat (8) tick();
    ROT_B = 1'b1; repeat (6) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if ({step1, dir1, pos1, step0, pos0} !== {1'b1, 1'b1, 8'd0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL clear_priority got step %b dir %b pos %0d / step %b pos %0d want 1 1 0 / 1 0",
               step1, dir1, pos1, step0, pos0);
    end
    repeat (4) tick();
  endtask

  task automatic test_random();
    do_reset();
    repeat (600) begin
      ROT_A = 1'($urandom_range(0, 1));
      ROT_B = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 60) != 0);
      tick();
      rst_n = 1'b1;
      clear = 1'b0;
      repeat ($urandom_range(0, 9)) tick();
    end
    checks++;
    if ({pos0, pos1} !== {mpos_wrap[7:0], mpos_sat[7:0]}) begin
      errors++;
      $display("FAIL random_final_pos got %0d/%0d want %0d/%0d", pos0, pos1, mpos_wrap, mpos_sat);
    end
  endtask

  initial begin
    test_reset();
    test_cw();
    test_ccw();
    test_short_pulse();
    test_glitch();
    test_reset_mid_debounce();
    test_limits_and_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
